// File: rtl/update_apply_unit.sv
// update_apply_unit: dual-lane min-apply stage writing a vertex value memory.
// Pipeline: S1 input capture (same-address lanes merged into lane A),
// S2 forwarded read and min compute, S3 output registers. The memory is
// written at the S2->S3 edge, so an update captured at edge k lands in memory
// and on Out* at edge k+2.
module update_apply_unit #(
    parameter int DATA_W = 32,
    parameter int VID_W  = 32,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              InputValid_A,
    input  logic [VID_W-1:0]  InDestVid_A,
    input  logic [DATA_W-1:0] InUpdate_A,
    input  logic              InputValid_B,
    input  logic [VID_W-1:0]  InDestVid_B,
    input  logic [DATA_W-1:0] InUpdate_B,
    output logic              OutValid_A,
    output logic [VID_W-1:0]  OutDestVid_A,
    output logic [DATA_W-1:0] OutValue_A,
    output logic              OutChanged_A,
    output logic              OutValid_B,
    output logic [VID_W-1:0]  OutDestVid_B,
    output logic [DATA_W-1:0] OutValue_B,
    output logic              OutChanged_B,
    output logic [CNT_W-1:0]  ChangeCount,
    input  logic              ClearCount,
    output logic              HostReady,
    input  logic              HostWrEn,
    input  logic              HostRdEn,
    input  logic [ADDR_W-1:0] HostAddr,
    input  logic [DATA_W-1:0] HostWrData,
    output logic [DATA_W-1:0] HostRdData,
    output logic              HostRdValid
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              s1ValidA, s1ValidB;
    logic [VID_W-1:0]  s1VidA, s1VidB;
    logic [DATA_W-1:0] s1UpdA, s1UpdB;

    logic              s2ValidA, s2ValidB;
    logic [VID_W-1:0]  s2VidA, s2VidB;
    logic [DATA_W-1:0] s2NewA, s2NewB;
    logic              s2ChgA, s2ChgB;

    logic [ADDR_W-1:0] s1AddrA, s1AddrB, s2AddrA, s2AddrB, outAddrA, outAddrB;
    logic [DATA_W-1:0] oldA, oldB;
    logic              sameIn, commitA, commitB, hostWr, hostRd;
    logic [CNT_W:0]    cntSum;

    assign s1AddrA  = s1VidA[ADDR_W-1:0];
    assign s1AddrB  = s1VidB[ADDR_W-1:0];
    assign s2AddrA  = s2VidA[ADDR_W-1:0];
    assign s2AddrB  = s2VidB[ADDR_W-1:0];
    assign outAddrA = OutDestVid_A[ADDR_W-1:0];
    assign outAddrB = OutDestVid_B[ADDR_W-1:0];

    assign sameIn  = InputValid_A && InputValid_B &&
                     (InDestVid_A[ADDR_W-1:0] == InDestVid_B[ADDR_W-1:0]);
    assign commitA = s2ValidA && s2ChgA;
    assign commitB = s2ValidB && s2ChgB;

    assign HostReady = !(s1ValidA || s1ValidB || s2ValidA || s2ValidB ||
                         OutValid_A || OutValid_B || InputValid_A || InputValid_B);
    assign hostWr = HostReady && HostWrEn;
    assign hostRd = HostReady && HostRdEn && !HostWrEn;

    // Latest value of a vertex: S2 result first, then S3, then memory.
    // Lanes never share an address within a stage, so lane order is irrelevant.
    function automatic logic [DATA_W-1:0] fwdRead(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = mem[a];
        if (s2ValidA && s2AddrA == a)
            v = s2NewA;
        else if (s2ValidB && s2AddrB == a)
            v = s2NewB;
        else if (OutValid_A && outAddrA == a)
            v = OutValue_A;
        else if (OutValid_B && outAddrB == a)
            v = OutValue_B;
        return v;
    endfunction

    // Forwarded old-value reads for both S1 lanes.
    always_comb begin
        oldA = fwdRead(s1AddrA);
        oldB = fwdRead(s1AddrB);
    end

    // S1: capture inputs, folding a same-address lane B into lane A.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1ValidA <= 1'b0;
            s1VidA   <= '0;
            s1UpdA   <= '0;
            s1ValidB <= 1'b0;
            s1VidB   <= '0;
            s1UpdB   <= '0;
        end else begin
            s1ValidA <= InputValid_A;
            s1VidA   <= InDestVid_A;
            s1UpdA   <= (sameIn && (InUpdate_B < InUpdate_A)) ? InUpdate_B : InUpdate_A;
            s1ValidB <= InputValid_B && !sameIn;
            s1VidB   <= InDestVid_B;
            s1UpdB   <= InUpdate_B;
        end
    end

    // S2: min against the forwarded old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2ValidA <= 1'b0;
            s2VidA   <= '0;
            s2NewA   <= '0;
            s2ChgA   <= 1'b0;
            s2ValidB <= 1'b0;
            s2VidB   <= '0;
            s2NewB   <= '0;
            s2ChgB   <= 1'b0;
        end else begin
            s2ValidA <= s1ValidA;
            s2VidA   <= s1VidA;
            s2NewA   <= (s1UpdA < oldA) ? s1UpdA : oldA;
            s2ChgA   <= s1UpdA < oldA;
            s2ValidB <= s1ValidB;
            s2VidB   <= s1VidB;
            s2NewB   <= (s1UpdB < oldB) ? s1UpdB : oldB;
            s2ChgB   <= s1UpdB < oldB;
        end
    end

    // S3: commit result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            OutValid_A   <= 1'b0;
            OutDestVid_A <= '0;
            OutValue_A   <= '0;
            OutChanged_A <= 1'b0;
            OutValid_B   <= 1'b0;
            OutDestVid_B <= '0;
            OutValue_B   <= '0;
            OutChanged_B <= 1'b0;
        end else begin
            OutValid_A   <= s2ValidA;
            OutDestVid_A <= s2VidA;
            OutValue_A   <= s2NewA;
            OutChanged_A <= commitA;
            OutValid_B   <= s2ValidB;
            OutDestVid_B <= s2VidB;
            OutValue_B   <= s2NewB;
            OutChanged_B <= commitB;
        end
    end

    // Vertex memory: reset to infinity; host writes only land when the pipe is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '1;
        end else begin
            if (hostWr)
                mem[HostAddr] <= HostWrData;
            if (commitA)
                mem[s2AddrA] <= s2NewA;
            if (commitB)
                mem[s2AddrB] <= s2NewB;
        end
    end

    // Changed-vertex counter, advanced on the same edge the commit lands.
    assign cntSum = {1'b0, ChangeCount} + (CNT_W+1)'(commitA) + (CNT_W+1)'(commitB);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ChangeCount <= '0;
        else if (ClearCount)
            ChangeCount <= '0;
        else if (cntSum[CNT_W])
            ChangeCount <= '1;
        else
            ChangeCount <= cntSum[CNT_W-1:0];
    end

    // Host read port: one-cycle registered read with a valid pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            HostRdData  <= '0;
            HostRdValid <= 1'b0;
        end else begin
            HostRdValid <= hostRd;
            if (hostRd)
                HostRdData <= mem[HostAddr];
        end
    end
endmodule

// File: tb/tb_update_apply_unit.sv
// tb_update_apply_unit: table vectors, directed corner sequences and a
// randomized run against an in-order sequential reference model.
module tb_update_apply_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        InputValid_A = 1'b0, InputValid_B = 1'b0;
    logic [31:0] InDestVid_A = '0, InDestVid_B = '0;
    logic [31:0] InUpdate_A = '0, InUpdate_B = '0;
    logic        ClearCount = 1'b0;
    logic        HostWrEn = 1'b0, HostRdEn = 1'b0;
    logic [7:0]  HostAddr = '0;
    logic [31:0] HostWrData = '0;

    logic        OutValid_A, OutChanged_A, OutValid_B, OutChanged_B;
    logic [31:0] OutDestVid_A, OutValue_A, OutDestVid_B, OutValue_B;
    logic [15:0] ChangeCount;
    logic        HostReady, HostRdValid;
    logic [31:0] HostRdData;

    logic        OutValid_A2, OutChanged_A2, OutValid_B2, OutChanged_B2;
    logic [31:0] OutDestVid_A2, OutValue_A2, OutDestVid_B2, OutValue_B2;
    logic [1:0]  ChangeCount2;
    logic        HostReady2, HostRdValid2;
    logic [31:0] HostRdData2;

    int total = 0;
    int bad = 0;

    update_apply_unit dut (
        .clk(clk), .rst(rst),
        .InputValid_A(InputValid_A), .InDestVid_A(InDestVid_A), .InUpdate_A(InUpdate_A),
        .InputValid_B(InputValid_B), .InDestVid_B(InDestVid_B), .InUpdate_B(InUpdate_B),
        .OutValid_A(OutValid_A), .OutDestVid_A(OutDestVid_A), .OutValue_A(OutValue_A),
        .OutChanged_A(OutChanged_A),
        .OutValid_B(OutValid_B), .OutDestVid_B(OutDestVid_B), .OutValue_B(OutValue_B),
        .OutChanged_B(OutChanged_B),
        .ChangeCount(ChangeCount), .ClearCount(ClearCount),
        .HostReady(HostReady), .HostWrEn(HostWrEn), .HostRdEn(HostRdEn),
        .HostAddr(HostAddr), .HostWrData(HostWrData),
        .HostRdData(HostRdData), .HostRdValid(HostRdValid)
    );

    // Narrow-counter instance sharing all stimulus, for saturation.
    update_apply_unit #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .InputValid_A(InputValid_A), .InDestVid_A(InDestVid_A), .InUpdate_A(InUpdate_A),
        .InputValid_B(InputValid_B), .InDestVid_B(InDestVid_B), .InUpdate_B(InUpdate_B),
        .OutValid_A(OutValid_A2), .OutDestVid_A(OutDestVid_A2), .OutValue_A(OutValue_A2),
        .OutChanged_A(OutChanged_A2),
        .OutValid_B(OutValid_B2), .OutDestVid_B(OutDestVid_B2), .OutValue_B(OutValue_B2),
        .OutChanged_B(OutChanged_B2),
        .ChangeCount(ChangeCount2), .ClearCount(ClearCount),
        .HostReady(HostReady2), .HostWrEn(HostWrEn), .HostRdEn(HostRdEn),
        .HostAddr(HostAddr), .HostWrData(HostWrData),
        .HostRdData(HostRdData2), .HostRdValid(HostRdValid2)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    typedef struct {
        logic        vA;
        logic [31:0] idA;
        logic [31:0] updA;
        logic        vB;
        logic [31:0] idB;
        logic [31:0] updB;
        logic        eVA;
        logic [31:0] eValA;
        logic        eChgA;
        logic        eVB;
        logic [31:0] eValB;
        logic        eChgB;
        logic [15:0] eCnt;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        InputValid_A = 1'b0;
        InputValid_B = 1'b0;
        ClearCount   = 1'b0;
        HostWrEn     = 1'b0;
        HostRdEn     = 1'b0;
    endtask

    task automatic doReset();
        idleInputs();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        step();
    endtask

    task automatic driveA(input logic [31:0] id, input logic [31:0] upd);
        InputValid_A = 1'b1;
        InDestVid_A  = id;
        InUpdate_A   = upd;
    endtask

    task automatic driveB(input logic [31:0] id, input logic [31:0] upd);
        InputValid_B = 1'b1;
        InDestVid_B  = id;
        InUpdate_B   = upd;
    endtask

    task automatic hostRead(input logic [7:0] a, input logic [31:0] exp, input string name);
        HostAddr = a;
        HostRdEn = 1'b1;
        check({name, "_ready"}, 64'(HostReady), 64'd1);
        step();
        HostRdEn = 1'b0;
        check({name, "_rdvalid"}, 64'(HostRdValid), 64'd1);
        check({name, "_rddata"}, 64'(HostRdData), 64'(exp));
        step();
        check({name, "_rdpulse"}, 64'(HostRdValid), 64'd0);
    endtask

    task automatic hostWrite(input logic [7:0] a, input logic [31:0] d, input string name);
        HostAddr   = a;
        HostWrData = d;
        HostWrEn   = 1'b1;
        check({name, "_ready"}, 64'(HostReady), 64'd1);
        step();
        HostWrEn = 1'b0;
    endtask

    task automatic checkA(input string name, input logic v, input logic [31:0] id,
                          input logic [31:0] val, input logic chg);
        check({name, "_validA"}, 64'(OutValid_A), 64'(v));
        if (v) begin
            check({name, "_vidA"}, 64'(OutDestVid_A), 64'(id));
            check({name, "_valueA"}, 64'(OutValue_A), 64'(val));
        end
        check({name, "_chgA"}, 64'(OutChanged_A), 64'(v && chg));
    endtask

    task automatic checkB(input string name, input logic v, input logic [31:0] id,
                          input logic [31:0] val, input logic chg);
        check({name, "_validB"}, 64'(OutValid_B), 64'(v));
        if (v) begin
            check({name, "_vidB"}, 64'(OutDestVid_B), 64'(id));
            check({name, "_valueB"}, 64'(OutValue_B), 64'(val));
        end
        check({name, "_chgB"}, 64'(OutChanged_B), 64'(v && chg));
    endtask

    task automatic checkCounts(input string name, input int exp);
        check({name, "_cnt"}, 64'(ChangeCount), 64'(exp));
        check({name, "_cnt2"}, 64'(ChangeCount2), 64'((exp > 3) ? 3 : exp));
    endtask

    localparam int NRAND = 300;
    logic [31:0] refMem [256];
    logic        eVa[4], eVb[4], eChgA[4], eChgB[4];
    logic [31:0] eIdA[4], eIdB[4], eValA[4], eValB[4];

    initial begin
        // Isolated transactions applied in order from reset memory.
        tbl[0] = '{1'b1, 32'd120, 32'd7, 1'b1, 32'd120, 32'd5,
                   1'b1, 32'd5, 1'b1, 1'b0, 32'd0, 1'b0, 16'd1};
        tbl[1] = '{1'b1, 32'd3, 32'd10, 1'b0, 32'd0, 32'd0,
                   1'b1, 32'd10, 1'b1, 1'b0, 32'd0, 1'b0, 16'd2};
        tbl[2] = '{1'b0, 32'd0, 32'd0, 1'b1, 32'd4, 32'd20,
                   1'b0, 32'd0, 1'b0, 1'b1, 32'd20, 1'b1, 16'd3};
        tbl[3] = '{1'b1, 32'd3, 32'd10, 1'b1, 32'd4, 32'd25,
                   1'b1, 32'd10, 1'b0, 1'b1, 32'd20, 1'b0, 16'd3};
        tbl[4] = '{1'b1, 32'h103, 32'd2, 1'b1, 32'd4, 32'd19,
                   1'b1, 32'd2, 1'b1, 1'b1, 32'd19, 1'b1, 16'd5};
        tbl[5] = '{1'b1, 32'd7, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd0,
                   1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 1'b0, 16'd5};
        tbl[6] = '{1'b1, 32'd9, 32'd1, 1'b1, 32'h209, 32'd0,
                   1'b1, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 16'd6};

        doReset();
        checkCounts("reset", 0);
        checkA("reset", 1'b0, 32'd0, 32'd0, 1'b0);
        checkB("reset", 1'b0, 32'd0, 32'd0, 1'b0);
        hostRead(8'd120, 32'hFFFF_FFFF, "rst_rd120");

        for (int t = 0; t < 7; t++) begin
            string nm;
            nm = $sformatf("tbl%0d", t);
            if (tbl[t].vA) driveA(tbl[t].idA, tbl[t].updA);
            if (tbl[t].vB) driveB(tbl[t].idB, tbl[t].updB);
            step();
            idleInputs();
            step();
            step();
            checkA(nm, tbl[t].eVA, tbl[t].idA, tbl[t].eValA, tbl[t].eChgA);
            checkB(nm, tbl[t].eVB, tbl[t].idB, tbl[t].eValB, tbl[t].eChgB);
            checkCounts(nm, int'(tbl[t].eCnt));
            step();
        end
        hostRead(8'd120, 32'd5, "tbl_rd120");
        hostRead(8'd3, 32'd2, "tbl_rd3");

        // Back-to-back updates to one vertex.
        doReset();
        driveA(32'd3, 32'd10); step();
        driveA(32'd3, 32'd9);  step();
        driveA(32'd3, 32'd12); step();
        checkA("b2b0", 1'b1, 32'd3, 32'd10, 1'b1);
        idleInputs(); step();
        checkA("b2b1", 1'b1, 32'd3, 32'd9, 1'b1);
        step();
        checkA("b2b2", 1'b1, 32'd3, 32'd9, 1'b0);
        checkCounts("b2b", 2);
        step();
        hostRead(8'd3, 32'd9, "b2b_rd3");

        // Reset with updates in flight.
        driveA(32'd20, 32'd1); step();
        idleInputs(); step();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        step();
        step();
        checkA("midrst", 1'b0, 32'd0, 32'd0, 1'b0);
        checkCounts("midrst", 0);
        hostRead(8'd20, 32'hFFFF_FFFF, "midrst_rd20");
        hostRead(8'd3, 32'hFFFF_FFFF, "midrst_rd3");

        // Cross-lane hazard: B then A on the same vertex.
        hostWrite(8'd8, 32'd100, "xl_wr8");
        driveB(32'd8, 32'd40); step();
        idleInputs();
        driveA(32'd8, 32'd50); step();
        idleInputs(); step();
        checkB("xlB", 1'b1, 32'd8, 32'd40, 1'b1);
        checkA("xlB", 1'b0, 32'd0, 32'd0, 1'b0);
        step();
        checkA("xlA", 1'b1, 32'd8, 32'd40, 1'b0);
        checkB("xlA", 1'b0, 32'd0, 32'd0, 1'b0);
        checkCounts("xl", 1);
        step();

        // Host write while busy is dropped.
        driveA(32'd5, 32'd30); step();
        idleInputs();
        HostAddr = 8'd5; HostWrData = 32'd1; HostWrEn = 1'b1;
        check("busy_ready", 64'(HostReady), 64'd0);
        step();
        HostWrEn = 1'b0;
        step();
        checkA("busy", 1'b1, 32'd5, 32'd30, 1'b1);
        step();
        hostRead(8'd5, 32'd30, "busy_rd5");
        hostWrite(8'd5, 32'd7, "busy_wr5");
        driveA(32'd5, 32'd7); step();
        idleInputs(); step(); step();
        checkA("eq", 1'b1, 32'd5, 32'd7, 1'b0);
        checkCounts("eq", 2);
        step();

        // Saturation and clear-beats-increment.
        doReset();
        for (int k = 0; k < 4; k++) begin
            driveA(32'(10 + k), 32'd4);
            step();
        end
        idleInputs(); step(); step();
        checkCounts("sat", 4);
        driveA(32'd14, 32'd1); step();
        idleInputs(); step();
        ClearCount = 1'b1; step();
        ClearCount = 1'b0;
        checkA("clr", 1'b1, 32'd14, 32'd1, 1'b1);
        checkCounts("clr", 0);
        step();
        checkCounts("clr_after", 0);

        // Randomized run against an in-order reference model.
        doReset();
        for (int a = 0; a < 256; a++) refMem[a] = 32'hFFFF_FFFF;
        for (int s = 0; s < 4; s++) begin
            eVa[s] = 1'b0; eVb[s] = 1'b0; eChgA[s] = 1'b0; eChgB[s] = 1'b0;
            eIdA[s] = '0; eIdB[s] = '0; eValA[s] = '0; eValB[s] = '0;
        end
        begin
            int refCnt;
            int refCnt2;
            refCnt = 0;
            refCnt2 = 0;
            for (int i = 0; i < NRAND + 2; i++) begin
                logic [31:0] r, uA, uB, old;
                logic        va, vb, clr;
                logic [7:0]  aA, aB;
                int          s, p, inc;
                if (i < NRAND) begin
                    r = $urandom;
                    InputValid_A = (r[1:0] != 2'd0);
                    InputValid_B = (r[3:2] != 2'd0);
                    r = $urandom;
                    InDestVid_A = {r[31:8], 5'd0, r[2:0]};
                    r = $urandom;
                    InDestVid_B = {r[31:8], 5'd0, r[2:0]};
                    InUpdate_A = $urandom_range(0, 2000);
                    InUpdate_B = $urandom_range(0, 2000);
                    ClearCount = ($urandom_range(0, 15) == 0);
                end else begin
                    idleInputs();
                end
                s   = i % 4;
                va  = InputValid_A;
                vb  = InputValid_B;
                aA  = InDestVid_A[7:0];
                aB  = InDestVid_B[7:0];
                uA  = InUpdate_A;
                uB  = InUpdate_B;
                clr = ClearCount;
                if (va && vb && aA == aB) begin
                    if (uB < uA) uA = uB;
                    vb = 1'b0;
                end
                eVa[s] = va;
                eIdA[s] = InDestVid_A;
                if (va) begin
                    old = refMem[aA];
                    eChgA[s] = uA < old;
                    eValA[s] = (uA < old) ? uA : old;
                    refMem[aA] = eValA[s];
                end
                eVb[s] = vb;
                eIdB[s] = InDestVid_B;
                if (vb) begin
                    old = refMem[aB];
                    eChgB[s] = uB < old;
                    eValB[s] = (uB < old) ? uB : old;
                    refMem[aB] = eValB[s];
                end
                step();
                p = (i + 2) % 4;
                checkA("rand", eVa[p], eIdA[p], eValA[p], eChgA[p]);
                checkB("rand", eVb[p], eIdB[p], eValB[p], eChgB[p]);
                inc = int'(eVa[p] && eChgA[p]) + int'(eVb[p] && eChgB[p]);
                if (clr) begin
                    refCnt = 0;
                    refCnt2 = 0;
                end else begin
                    refCnt  = (refCnt + inc > 65535) ? 65535 : refCnt + inc;
                    refCnt2 = (refCnt2 + inc > 3) ? 3 : refCnt2 + inc;
                end
                check("rand_cnt", 64'(ChangeCount), 64'(refCnt));
                check("rand_cnt2", 64'(ChangeCount2), 64'(refCnt2));
            end
        end
        step();
        for (int a = 0; a < 8; a++)
            hostRead(8'(a), refMem[a], $sformatf("rand_rd%0d", a));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
